// File: rtl/i2c_txn_arbiter_if.sv
// rtl/i2c_txn_arbiter_if.sv - requester, response and I2C master signals of the transaction arbiter
interface i2c_txn_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [6:0] req0_dev;
  logic [7:0] req0_reg;
  logic [7:0] req0_wdata;
  logic       req0_rw;
  logic       rsp0_valid;

  logic       req1_valid;
  logic       req1_ready;
  logic [6:0] req1_dev;
  logic [7:0] req1_reg;
  logic [7:0] req1_wdata;
  logic       req1_rw;
  logic       rsp1_valid;

  logic [7:0] rsp_rdata;
  logic [1:0] rsp_status;

  logic       m_start;
  logic       m_abort;
  logic [6:0] Dev_addr;
  logic [7:0] Reg_addr;
  logic [7:0] Data_in;
  logic       RW_sel;
  logic       m_done;
  logic       m_nack;
  logic [7:0] m_rdata;

  logic       arb_busy;

  // Arbiter view: it masters the I2C engine and serves both requesters.
  modport master (
    input  req0_valid, req0_dev, req0_reg, req0_wdata, req0_rw,
    input  req1_valid, req1_dev, req1_reg, req1_wdata, req1_rw,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata, rsp_status,
    output m_start, m_abort, Dev_addr, Reg_addr, Data_in, RW_sel, arb_busy,
    input  m_done, m_nack, m_rdata
  );

  modport slave (
    output req0_valid, req0_dev, req0_reg, req0_wdata, req0_rw,
    output req1_valid, req1_dev, req1_reg, req1_wdata, req1_rw,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata, rsp_status,
    input  m_start, m_abort, Dev_addr, Reg_addr, Data_in, RW_sel, arb_busy,
    output m_done, m_nack, m_rdata
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin arbiter sequencing single-byte I2C register transactions
module i2c_txn_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  i2c_txn_arbiter_if.master    bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic            last_grant;
  logic            grant;
  logic [TO_W-1:0] cnt;
  logic            gnt0;
  logic            gnt1;

  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt0 = bus.req0_valid & (~bus.req1_valid | last_grant);
    gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
  end

  assign bus.req0_ready = rst & (state == IDLE) & gnt0;
  assign bus.req1_ready = rst & (state == IDLE) & gnt1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      grant          <= 1'b0;
      cnt            <= '0;
      bus.m_start    <= 1'b0;
      bus.m_abort    <= 1'b0;
      bus.Dev_addr   <= '0;
      bus.Reg_addr   <= '0;
      bus.Data_in    <= '0;
      bus.RW_sel     <= 1'b0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp_rdata  <= '0;
      bus.rsp_status <= '0;
      bus.arb_busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 | gnt1) begin
            grant        <= gnt1;
            bus.Dev_addr <= gnt1 ? bus.req1_dev   : bus.req0_dev;
            bus.Reg_addr <= gnt1 ? bus.req1_reg   : bus.req0_reg;
            bus.Data_in  <= gnt1 ? bus.req1_wdata : bus.req0_wdata;
            bus.RW_sel   <= gnt1 ? bus.req1_rw    : bus.req0_rw;
            bus.m_start  <= 1'b1;
            bus.arb_busy <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          bus.m_start <= 1'b0;
          cnt         <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // Completion has priority over a timeout landing on the same cycle.
          if (bus.m_done) begin
            bus.rsp_status <= bus.m_nack ? 2'b01 : 2'b00;
            bus.rsp_rdata  <= bus.RW_sel ? bus.m_rdata : 8'h00;
            bus.rsp0_valid <= ~grant;
            bus.rsp1_valid <= grant;
            state          <= RESP;
          end else if (cnt == TO_LAST) begin
            bus.m_abort    <= 1'b1;
            bus.rsp_status <= 2'b10;
            bus.rsp_rdata  <= 8'h00;
            bus.rsp0_valid <= ~grant;
            bus.rsp1_valid <= grant;
            state          <= RESP;
          end
        end
        RESP: begin
          bus.rsp0_valid <= 1'b0;
          bus.rsp1_valid <= 1'b0;
          bus.m_abort    <= 1'b0;
          bus.arb_busy   <= 1'b0;
          last_grant     <= grant;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb/tb_i2c_txn_arbiter.sv - directed self-checking bench for i2c_txn_arbiter
module tb_i2c_txn_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  i2c_txn_arbiter_if bus ();
  i2c_txn_arbiter_if bus2 ();

  i2c_txn_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Short-timeout instance used only for the timeout boundary.
  i2c_txn_arbiter #(.TIMEOUT_CYCLES(16), .TO_W(4)) dut_to (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 0; bus.req0_dev = 0; bus.req0_reg = 0; bus.req0_wdata = 0; bus.req0_rw = 0;
    bus.req1_valid = 0; bus.req1_dev = 0; bus.req1_reg = 0; bus.req1_wdata = 0; bus.req1_rw = 0;
    bus.m_done = 0; bus.m_nack = 0; bus.m_rdata = 0;
    bus2.req0_valid = 0; bus2.req0_dev = 0; bus2.req0_reg = 0; bus2.req0_wdata = 0; bus2.req0_rw = 0;
    bus2.req1_valid = 0; bus2.req1_dev = 0; bus2.req1_reg = 0; bus2.req1_wdata = 0; bus2.req1_rw = 0;
    bus2.m_done = 0; bus2.m_nack = 0; bus2.m_rdata = 0;
  endtask

  task automatic set_req(input bit who, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input logic rw);
    if (who == 1'b0) begin
      bus.req0_dev = dev; bus.req0_reg = rg; bus.req0_wdata = wd; bus.req0_rw = rw; bus.req0_valid = 1;
    end else begin
      bus.req1_dev = dev; bus.req1_reg = rg; bus.req1_wdata = wd; bus.req1_rw = rw; bus.req1_valid = 1;
    end
  endtask

  task automatic run_txn(input bit who);
    set_req(who, 7'h0F, 8'h01, 8'h02, 1'b0);
    tick();
    bus.req0_valid = 0; bus.req1_valid = 0;
    tick();
    bus.m_done = 1;
    tick();
    bus.m_done = 0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    tick(); tick();
    checks++;
    if ({bus.m_start, bus.m_abort, bus.arb_busy, bus.rsp0_valid, bus.rsp1_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected %b",
               {bus.m_start, bus.m_abort, bus.arb_busy, bus.rsp0_valid, bus.rsp1_valid}, 5'b0);
    end
    checks++;
    if ({bus.Dev_addr, bus.Reg_addr, bus.Data_in, bus.RW_sel, bus.rsp_rdata, bus.rsp_status} !== 34'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0",
               {bus.Dev_addr, bus.Reg_addr, bus.Data_in, bus.RW_sel, bus.rsp_rdata, bus.rsp_status});
    end
    bus.req0_valid = 1;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: got %b expected %b", {bus.req0_ready, bus.req1_ready}, 2'b00);
    end
    bus.req0_valid = 0;
    rst = 1;
    tick();
  endtask

  task automatic test_single_write();
    set_req(0, 7'h55, 8'hD5, 8'h55, 1'b0);
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL wr_ready: got %b expected %b", {bus.req0_ready, bus.req1_ready}, 2'b10);
    end
    tick();
    bus.req0_valid = 0;
    checks++;
    if ({bus.m_start, bus.arb_busy, bus.Dev_addr, bus.Reg_addr, bus.Data_in, bus.RW_sel} !=
        {1'b1, 1'b1, 7'h55, 8'hD5, 8'h55, 1'b0}) begin
      errors++;
      $display("FAIL wr_issue: got start=%b busy=%b dev=%h reg=%h data=%h rw=%b expected 1 1 55 d5 55 0",
               bus.m_start, bus.arb_busy, bus.Dev_addr, bus.Reg_addr, bus.Data_in, bus.RW_sel);
    end
    tick();
    checks++;
    if (bus.m_start !== 1'b0) begin
      errors++;
      $display("FAIL wr_start_pulse: got %b expected 0", bus.m_start);
    end
    repeat (19) tick();
    bus.m_done = 1; bus.m_nack = 0; bus.m_rdata = 8'h3C;
    tick();
    bus.m_done = 0;
    checks++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp_status, bus.rsp_rdata, bus.m_abort} !=
        {2'b10, 2'b00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL wr_resp: got rsp=%b%b status=%b rdata=%h abort=%b expected 10 00 00 0",
               bus.rsp0_valid, bus.rsp1_valid, bus.rsp_status, bus.rsp_rdata, bus.m_abort);
    end
    tick();
    checks++;
    if ({bus.rsp0_valid, bus.arb_busy, bus.Dev_addr} !== {1'b0, 1'b0, 7'h55}) begin
      errors++;
      $display("FAIL wr_idle: got rsp0=%b busy=%b dev=%h expected 0 0 55",
               bus.rsp0_valid, bus.arb_busy, bus.Dev_addr);
    end
  endtask

  task automatic test_read();
    set_req(1, 7'h21, 8'h10, 8'h00, 1'b1);
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rd_ready: got %b expected %b", {bus.req0_ready, bus.req1_ready}, 2'b01);
    end
    tick();
    bus.req1_valid = 0;
    checks++;
    if ({bus.m_start, bus.Dev_addr, bus.Reg_addr, bus.RW_sel} !== {1'b1, 7'h21, 8'h10, 1'b1}) begin
      errors++;
      $display("FAIL rd_issue: got start=%b dev=%h reg=%h rw=%b expected 1 21 10 1",
               bus.m_start, bus.Dev_addr, bus.Reg_addr, bus.RW_sel);
    end
    repeat (4) tick();
    bus.m_done = 1; bus.m_rdata = 8'hA7;
    tick();
    bus.m_done = 0;
    checks++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp_status, bus.rsp_rdata} !== {2'b01, 2'b00, 8'hA7}) begin
      errors++;
      $display("FAIL rd_resp: got rsp=%b%b status=%b rdata=%h expected 01 00 a7",
               bus.rsp0_valid, bus.rsp1_valid, bus.rsp_status, bus.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_nack();
    set_req(0, 7'h30, 8'h44, 8'h99, 1'b0);
    tick();
    bus.req0_valid = 0;
    tick();
    bus.m_done = 1; bus.m_nack = 1; bus.m_rdata = 8'hEE;
    tick();
    bus.m_done = 0; bus.m_nack = 0;
    checks++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp_status, bus.rsp_rdata} !== {2'b10, 2'b01, 8'h00}) begin
      errors++;
      $display("FAIL nack_resp: got rsp=%b%b status=%b rdata=%h expected 10 01 00",
               bus.rsp0_valid, bus.rsp1_valid, bus.rsp_status, bus.rsp_rdata);
    end
    tick();
    checks++;
    if (bus.rsp_status !== 2'b01) begin
      errors++;
      $display("FAIL nack_hold: got %b expected 01", bus.rsp_status);
    end
  endtask

  task automatic test_done_ignored();
    bus.m_done = 1;
    tick();
    bus.m_done = 0;
    checks++;
    if ({bus.arb_busy, bus.rsp0_valid, bus.rsp1_valid} !== 3'b000) begin
      errors++;
      $display("FAIL idle_done: got %b expected 000", {bus.arb_busy, bus.rsp0_valid, bus.rsp1_valid});
    end
    set_req(1, 7'h12, 8'h34, 8'h56, 1'b0);
    tick();
    bus.req1_valid = 0;
    bus.m_done = 1;
    tick();
    bus.m_done = 0;
    checks++;
    if ({bus.arb_busy, bus.rsp0_valid, bus.rsp1_valid} !== 3'b100) begin
      errors++;
      $display("FAIL issue_done: got %b expected 100", {bus.arb_busy, bus.rsp0_valid, bus.rsp1_valid});
    end
    bus.m_done = 1;
    tick();
    bus.m_done = 0;
    checks++;
    if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b01) begin
      errors++;
      $display("FAIL wait_done: got %b expected 01", {bus.rsp0_valid, bus.rsp1_valid});
    end
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] exp;
    logic [6:0] exp_dev;
    rst = 0;
    tick();
    rst = 1;
    set_req(0, 7'h11, 8'hA0, 8'hB0, 1'b0);
    set_req(1, 7'h22, 8'hA1, 8'hB1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp     = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_dev = (i % 2 == 0) ? 7'h11 : 7'h22;
      #1;
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== exp) begin
        errors++;
        $display("FAIL cont_grant%0d: got %b expected %b", i, {bus.req0_ready, bus.req1_ready}, exp);
      end
      tick();
      checks++;
      if ({bus.m_start, bus.Dev_addr, bus.req0_ready, bus.req1_ready} !== {1'b1, exp_dev, 2'b00}) begin
        errors++;
        $display("FAIL cont_issue%0d: got start=%b dev=%h ready=%b%b expected 1 %h 00",
                 i, bus.m_start, bus.Dev_addr, bus.req0_ready, bus.req1_ready, exp_dev);
      end
      tick();
      bus.m_done = 1;
      tick();
      bus.m_done = 0;
      checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid} !== exp) begin
        errors++;
        $display("FAIL cont_rsp%0d: got %b expected %b", i, {bus.rsp0_valid, bus.rsp1_valid}, exp);
      end
      tick();
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    run_txn(0);
    set_req(1, 7'h44, 8'h55, 8'h66, 1'b1);
    tick();
    bus.req1_valid = 0;
    repeat (3) tick();
    rst = 0;
    tick();
    rst = 1;
    checks++;
    if ({bus.m_start, bus.m_abort, bus.arb_busy, bus.rsp0_valid, bus.rsp1_valid,
         bus.Dev_addr, bus.Reg_addr, bus.Data_in, bus.RW_sel, bus.rsp_rdata, bus.rsp_status} !== 39'h0) begin
      errors++;
      $display("FAIL midrst_outs: got busy=%b abort=%b rsp=%b%b dev=%h expected all zero",
               bus.arb_busy, bus.m_abort, bus.rsp0_valid, bus.rsp1_valid, bus.Dev_addr);
    end
    bus.m_done = 1;
    tick();
    bus.m_done = 0;
    checks++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.m_abort, bus.arb_busy} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_norsp: got %b expected 0000",
               {bus.rsp0_valid, bus.rsp1_valid, bus.m_abort, bus.arb_busy});
    end
    set_req(0, 7'h01, 8'h02, 8'h03, 1'b0);
    set_req(1, 7'h04, 8'h05, 8'h06, 1'b0);
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_tie: got %b expected %b", {bus.req0_ready, bus.req1_ready}, 2'b10);
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    tick();
  endtask

  task automatic test_timeout();
    bus2.req0_dev = 7'h2A; bus2.req0_reg = 8'h01; bus2.req0_rw = 1'b1; bus2.req0_valid = 1;
    bus2.m_rdata = 8'h99;
    tick();
    bus2.req0_valid = 0;
    tick();
    repeat (15) tick();
    checks++;
    if ({bus2.m_abort, bus2.rsp0_valid, bus2.arb_busy} !== 3'b001) begin
      errors++;
      $display("FAIL to_before: got %b expected 001", {bus2.m_abort, bus2.rsp0_valid, bus2.arb_busy});
    end
    tick();
    checks++;
    if ({bus2.m_abort, bus2.rsp0_valid, bus2.rsp1_valid, bus2.rsp_status, bus2.rsp_rdata} !==
        {3'b110, 2'b10, 8'h00}) begin
      errors++;
      $display("FAIL to_abort: got abort=%b rsp=%b%b status=%b rdata=%h expected 1 10 10 00",
               bus2.m_abort, bus2.rsp0_valid, bus2.rsp1_valid, bus2.rsp_status, bus2.rsp_rdata);
    end
    tick();
    checks++;
    if ({bus2.m_abort, bus2.rsp0_valid} !== 2'b00) begin
      errors++;
      $display("FAIL to_pulse: got %b expected 00", {bus2.m_abort, bus2.rsp0_valid});
    end
    bus2.req0_rw = 1'b0; bus2.req0_valid = 1;
    tick();
    bus2.req0_valid = 0;
    tick();
    repeat (15) tick();
    bus2.m_done = 1;
    tick();
    bus2.m_done = 0;
    checks++;
    if ({bus2.m_abort, bus2.rsp0_valid, bus2.rsp_status} !== {2'b01, 2'b00}) begin
      errors++;
      $display("FAIL to_done_wins: got abort=%b rsp0=%b status=%b expected 0 1 00",
               bus2.m_abort, bus2.rsp0_valid, bus2.rsp_status);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_nack();
    test_done_ignored();
    test_contention();
    test_reset_mid_wait();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
